// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the dmem_arbiter block.
// The optional read-modify-write path is enabled with DMEM_ARB_RMW_EN.
package dmem_arb_pkg;

    localparam int NUM_REQ     = 2;
    localparam int WORD_ADDR_W = 30;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RMW_WR = 2'd2
    } dmem_arb_state_t;

    typedef struct packed {
        logic                   we;
        logic [WORD_ADDR_W-1:0] addr;
        logic [31:0]            wdata;
        logic [3:0]             wstrb;
    } dmem_req_t;

    // A strobe that is neither empty nor full needs the old word merged in.
    function automatic logic is_partial(input logic [3:0] wstrb);
        return (wstrb != 4'h0) && (wstrb != 4'hF);
    endfunction

endpackage

// File: rtl/dmem_arb_if.sv
// Requester-side and memory-side signals of dmem_arbiter.
// slave = arbiter view, master = requesters/memory view.
interface dmem_arb_if #(
    parameter int ADDR_W = 32
);

    logic              m0_req;
    logic              m0_we;
    logic [ADDR_W-1:0] m0_addr;
    logic [31:0]       m0_wdata;
    logic [3:0]        m0_wstrb;
    logic              m0_gnt;
    logic              m0_rvalid;
    logic [31:0]       m0_rdata;

    logic              m1_req;
    logic              m1_we;
    logic [ADDR_W-1:0] m1_addr;
    logic [31:0]       m1_wdata;
    logic [3:0]        m1_wstrb;
    logic              m1_gnt;
    logic              m1_rvalid;
    logic [31:0]       m1_rdata;

    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata, m0_wstrb,
        input  m1_req, m1_we, m1_addr, m1_wdata, m1_wstrb,
        input  mem_rdata,
        output m0_gnt, m0_rvalid, m0_rdata,
        output m1_gnt, m1_rvalid, m1_rdata,
        output mem_read, mem_write, mem_addr, mem_wdata
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata, m0_wstrb,
        output m1_req, m1_we, m1_addr, m1_wdata, m1_wstrb,
        output mem_rdata,
        input  m0_gnt, m0_rvalid, m0_rdata,
        input  m1_gnt, m1_rvalid, m1_rdata,
        input  mem_read, mem_write, mem_addr, mem_wdata
    );

endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-input round-robin arbiter: combinational grant, registered priority.
module rr_arb2
    import dmem_arb_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic               winner
);

    logic prio_q;

    always_comb begin
        grant = '0;
        if (en) begin
            if (req == 2'b11) grant = prio_q ? 2'b10 : 2'b01;
            else              grant = req;
        end
    end

    assign winner = grant[1];

    // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         prio_q <= 1'b0;
        else if (|grant) prio_q <= ~winner;
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter/sequencer in front of a single-port word memory.
// Define DMEM_ARB_RMW_EN to turn partial-strobe writes into read-modify-write.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic      clk,
    input  logic      rst,
    dmem_arb_if.slave bus
);

    dmem_arb_state_t    state_q, state_d;
    logic [NUM_REQ-1:0] req_vec, gnt_vec;
    logic               win_id, arb_en, done;
    logic               id_q;
    dmem_req_t          req_q, win_req;
    logic [NUM_REQ-1:0] rvalid_q;
    logic [DATA_W-1:0]  rdata_q;

    assign req_vec = {bus.m1_req, bus.m0_req};
    // Arbitration is blocked during reset so no grant is visible while rst is high.
    assign arb_en  = (state_q == IDLE) && !rst;

    rr_arb2 u_rr_arb2 (
        .clk    (clk),
        .rst    (rst),
        .en     (arb_en),
        .req    (req_vec),
        .grant  (gnt_vec),
        .winner (win_id)
    );

    assign bus.m0_gnt = gnt_vec[0];
    assign bus.m1_gnt = gnt_vec[1];

    always_comb begin
        if (win_id) begin
            win_req = '{we: bus.m1_we, addr: bus.m1_addr[ADDR_W-1:2],
                        wdata: bus.m1_wdata, wstrb: bus.m1_wstrb};
        end else begin
            win_req = '{we: bus.m0_we, addr: bus.m0_addr[ADDR_W-1:2],
                        wdata: bus.m0_wdata, wstrb: bus.m0_wstrb};
        end
    end

`ifdef DMEM_ARB_RMW_EN
    logic [31:0] old_q, merged;

    always_comb begin
        merged = old_q;
        for (int i = 0; i < 4; i++) begin
            if (req_q.wstrb[i]) merged[8*i +: 8] = req_q.wdata[8*i +: 8];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                   old_q <= '0;
        else if (state_q == ACCESS) old_q <= bus.mem_rdata;
    end
`endif

    // Memory strobes decode from registered state only; reset clears state asynchronously.
    always_comb begin
        // NOTE: every output gets a default first, so no path through the case infers a latch.
        state_d       = state_q;
        done          = 1'b0;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        case (state_q)
            IDLE: begin
                if (|gnt_vec) state_d = ACCESS;
            end
            ACCESS: begin
                bus.mem_addr = ADDR_W'({req_q.addr, 2'b00});
                if (!req_q.we) begin
                    bus.mem_read = 1'b1;
                    done         = 1'b1;
                    state_d      = IDLE;
                end
`ifdef DMEM_ARB_RMW_EN
                else if (is_partial(req_q.wstrb)) begin
                    bus.mem_read = 1'b1;
                    state_d      = RMW_WR;
                end
`endif
                else begin
                    bus.mem_write = |req_q.wstrb;
                    bus.mem_wdata = req_q.wdata;
                    done          = 1'b1;
                    state_d       = IDLE;
                end
            end
`ifdef DMEM_ARB_RMW_EN
            RMW_WR: begin
                bus.mem_addr  = ADDR_W'({req_q.addr, 2'b00});
                bus.mem_write = 1'b1;
                bus.mem_wdata = merged;
                done          = 1'b1;
                state_d       = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_q    <= '0;
            id_q     <= 1'b0;
            rvalid_q <= '0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= '0;
            rdata_q  <= '0;
            if (|gnt_vec) begin
                req_q <= win_req;
                id_q  <= win_id;
            end
            if (done) begin
                rvalid_q[id_q] <= 1'b1;
                rdata_q        <= req_q.we ? '0 : bus.mem_rdata;
            end
        end
    end

    assign bus.m0_rvalid = rvalid_q[0];
    assign bus.m1_rvalid = rvalid_q[1];
    assign bus.m0_rdata  = rvalid_q[0] ? rdata_q : '0;
    assign bus.m1_rdata  = rvalid_q[1] ? rdata_q : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: random and directed requests checked against a word-level model.
module tb_dmem_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;

    dmem_arb_if #(.ADDR_W(32)) bus ();

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

`ifdef DMEM_ARB_RMW_EN
    localparam bit RMW = 1'b1;
`else
    localparam bit RMW = 1'b0;
`endif

    int cyc   = 0;
    int total = 0;
    int bad   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory device: combinational read gated by mem_read, synchronous write.
    logic [31:0] mem [16];
    logic [31:0] shadow [16];

    assign bus.mem_rdata = bus.mem_read ? mem[bus.mem_addr[5:2]] : 32'h0;

    always @(posedge clk) if (bus.mem_write) mem[bus.mem_addr[5:2]] <= bus.mem_wdata;

    typedef struct {
        int          id;
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t exp_q[$];
    bit   mon_en = 1'b0;

    bit          act     [2];
    logic        we_s    [2];
    logic [31:0] addr_s  [2];
    logic [31:0] wdata_s [2];
    logic [3:0]  wstrb_s [2];
    int          prio_m  = 0;
    int          free_at = 0;

    logic [3:0] st_tab [8] = '{4'h0, 4'hF, 4'h1, 4'h6, 4'h8, 4'h3, 4'hC, 4'hF};

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] wd,
                                          input logic [3:0] st);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = st[i] ? wd[8*i +: 8] : old_w[8*i +: 8];
        return r;
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [3:0] w;
        logic [1:0] b;
        w = 4'($urandom_range(0, 15));
        b = 2'($urandom_range(0, 3));
        return {26'h0, w, b};
    endfunction

    task automatic set_req(input int k, input logic we, input logic [31:0] a,
                           input logic [31:0] wd, input logic [3:0] st);
        act[k] = 1'b1; we_s[k] = we; addr_s[k] = a; wdata_s[k] = wd; wstrb_s[k] = st;
    endtask

    task automatic drive();
        bus.m0_req = act[0]; bus.m0_we = we_s[0]; bus.m0_addr = addr_s[0];
        bus.m0_wdata = wdata_s[0]; bus.m0_wstrb = wstrb_s[0];
        bus.m1_req = act[1]; bus.m1_we = we_s[1]; bus.m1_addr = addr_s[1];
        bus.m1_wdata = wdata_s[1]; bus.m1_wstrb = wstrb_s[1];
    endtask

    // Reference model: one transaction at a time, round-robin on ties, memory as an array.
    task automatic model_cycle();
        logic [1:0] eg;
        int w, lat, idx;
        exp_t e;
        eg = 2'b00;
        w  = 0;
        if (cyc >= free_at && (act[0] || act[1])) begin
            w = (act[0] && act[1]) ? prio_m : (act[1] ? 1 : 0);
            eg[w] = 1'b1;
        end
        check("grant", 32'({bus.m1_gnt, bus.m0_gnt}), 32'(eg));
        if (eg != 2'b00) begin
            idx    = int'(addr_s[w][5:2]);
            lat    = 2;
            e.id   = w;
            e.data = 32'h0;
            if (!we_s[w]) begin
                e.data = shadow[idx];
            end else if (wstrb_s[w] != 4'h0) begin
                if (RMW && wstrb_s[w] != 4'hF) begin
                    shadow[idx] = merge(shadow[idx], wdata_s[w], wstrb_s[w]);
                    lat = 3;
                end else begin
                    shadow[idx] = wdata_s[w];
                end
            end
            e.due   = cyc + lat;
            free_at = cyc + lat;
            prio_m  = 1 - w;
            act[w]  = 1'b0;
            exp_q.push_back(e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        drive();
        @(negedge clk);
        model_cycle();
    endtask

    task automatic drain();
        for (int i = 0; i < 30; i++) begin
            if (!act[0] && !act[1] && exp_q.size() == 0) break;
            step();
        end
        check("drained", 32'(exp_q.size()), 32'h0);
    endtask

    // Monitor: pops the scoreboard whenever a completion pulse is presented.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            check("mem_rw_excl", 32'(bus.mem_read & bus.mem_write), 32'h0);
            if (!bus.m0_rvalid) check("m0_rdata_idle", bus.m0_rdata, 32'h0);
            if (!bus.m1_rvalid) check("m1_rdata_idle", bus.m1_rdata, 32'h0);
            if (bus.m0_rvalid || bus.m1_rvalid) begin
                if (exp_q.size() == 0) begin
                    check("rsp_expected", 32'({bus.m1_rvalid, bus.m0_rvalid}), 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_who", 32'({bus.m1_rvalid, bus.m0_rvalid}), (e.id == 1) ? 32'h2 : 32'h1);
                    check("rsp_data", (e.id == 1) ? bus.m1_rdata : bus.m0_rdata, e.data);
                    check("rsp_cycle", 32'(cyc), 32'(e.due));
                end
            end else if (exp_q.size() != 0 && exp_q[0].due < cyc) begin
                check("rsp_late", 32'(cyc), 32'(exp_q[0].due));
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] saved;
        int g_cyc[$];
        int wins[$];

        for (int i = 0; i < 16; i++) mem[i] = $urandom;
        mem[4] = 32'hDEADBEEF;
        mem[7] = 32'h11223344;
        mem[9] = 32'hCAFEF00D;
        for (int i = 0; i < 16; i++) shadow[i] = mem[i];
        for (int k = 0; k < 2; k++) begin
            act[k] = 1'b0; we_s[k] = 1'b0; addr_s[k] = '0; wdata_s[k] = '0; wstrb_s[k] = '0;
        end
        drive();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_ctrl", 32'({bus.m0_gnt, bus.m1_gnt, bus.m0_rvalid, bus.m1_rvalid,
                               bus.mem_read, bus.mem_write}), 32'h0);
        check("rst_mem_addr", bus.mem_addr, 32'h0);
        check("rst_rdata", bus.m0_rdata | bus.m1_rdata | bus.mem_wdata, 32'h0);
        @(negedge clk);
        rst    = 1'b0;
        mon_en = 1'b1;

        // m0 reads word 4
        set_req(0, 1'b0, 32'h10, 32'h0, 4'h0);
        step();
        check("t1_gnt", 32'(bus.m0_gnt), 32'h1);
        step();
        check("t1_mem_read", 32'(bus.mem_read), 32'h1);
        check("t1_mem_addr", bus.mem_addr, 32'h10);
        step();
        check("t1_rvalid", 32'(bus.m0_rvalid), 32'h1);
        check("t1_rdata", bus.m0_rdata, 32'hDEADBEEF);

        // Both requesters continuously reading: grants alternate, one every 2 cycles
        for (int n = 0; n < 40 && wins.size() < 8; n++) begin
            if (!act[0]) set_req(0, 1'b0, rand_addr(), 32'h0, 4'h0);
            if (!act[1]) set_req(1, 1'b0, rand_addr(), 32'h0, 4'h0);
            step();
            if (bus.m0_gnt || bus.m1_gnt) begin
                wins.push_back(int'(bus.m1_gnt));
                g_cyc.push_back(cyc);
            end
        end
        check("t2_grants", 32'(wins.size()), 32'd8);
        for (int i = 1; i < wins.size(); i++) begin
            check("t2_alternate", 32'(wins[i]), 32'(1 - wins[i-1]));
            check("t2_pitch", 32'(g_cyc[i] - g_cyc[i-1]), 32'd2);
        end
        drain();

        // m1 byte-0 write to word 7 holding 0x11223344
        set_req(1, 1'b1, 32'h1C, 32'h000000AB, 4'b0001);
        step();
        check("t3_gnt", 32'(bus.m1_gnt), 32'h1);
        step();
`ifdef DMEM_ARB_RMW_EN
        check("t3_rmw_read", 32'({bus.mem_read, bus.mem_write}), 32'h2);
        step();
        check("t3_rmw_write", 32'({bus.mem_read, bus.mem_write}), 32'h1);
        check("t3_merged", bus.mem_wdata, 32'h112233AB);
`else
        check("t3_write", 32'({bus.mem_read, bus.mem_write}), 32'h1);
        check("t3_wdata", bus.mem_wdata, 32'h000000AB);
`endif
        step();
        check("t3_rvalid", 32'(bus.m1_rvalid), 32'h1);
        drain();

        // m0 write with empty strobe: no memory write, still completes
        set_req(0, 1'b1, 32'h20, 32'h55AA55AA, 4'h0);
        step();
        check("t4_gnt", 32'(bus.m0_gnt), 32'h1);
        step();
        check("t4_no_write", 32'(bus.mem_write), 32'h0);
        step();
        check("t4_rvalid", 32'(bus.m0_rvalid), 32'h1);
        drain();

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            for (int k = 0; k < 2; k++) begin
                if (!act[k] && $urandom_range(0, 1) == 1)
                    set_req(k, 1'($urandom_range(0, 1)), rand_addr(), $urandom,
                            st_tab[$urandom_range(0, 7)]);
            end
            step();
        end
        drain();
        for (int i = 0; i < 16; i++) check("mem_contents", mem[i], shadow[i]);

        // Reset in the middle of a partial write
        saved = shadow[9];
        set_req(1, 1'b1, 32'h24, 32'h99887766, 4'b0110);
        step();
        check("t5_gnt", 32'(bus.m1_gnt), 32'h1);
`ifdef DMEM_ARB_RMW_EN
        step();
        @(posedge clk);
        #1;
        check("t5_in_rmw_wr", 32'(bus.mem_write), 32'h1);
`else
        @(posedge clk);
        #1;
        check("t5_in_write", 32'(bus.mem_write), 32'h1);
`endif
        mon_en = 1'b0;
        rst    = 1'b1;
        #1;
        check("t5_write_drop", 32'({bus.mem_read, bus.mem_write}), 32'h0);
        exp_q.delete();
        shadow[9] = saved;
        prio_m    = 0;
        free_at   = 0;
        act[0]    = 1'b0;
        act[1]    = 1'b0;
        drive();
        repeat (3) begin
            @(negedge clk);
            check("t5_no_rvalid", 32'({bus.m1_rvalid, bus.m0_rvalid}), 32'h0);
        end
        check("t5_mem_kept", mem[9], saved);
        rst    = 1'b0;
        mon_en = 1'b1;
        set_req(0, 1'b0, 32'h24, 32'h0, 4'h0);
        set_req(1, 1'b0, 32'h28, 32'h0, 4'h0);
        step();
        check("t5_first_gnt", 32'({bus.m1_gnt, bus.m0_gnt}), 32'h1);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and sequencer in front of the single-port, word-wide data memory (combinational read gated by `memread`, synchronous write on `memwrite`). It shares that memory between requester 0 (core load/store unit) and requester 1 (debug/loader port) with round-robin fairness. It also sequences sub-word stores (byte-strobed) as read-modify-write, because the memory only writes whole words.

## Interface
Parameters:
- `ADDR_W`, 32: byte-address width on all ports.
- `DATA_W`, 32: data width; fixed at 32 (4 byte lanes).

Ports:
- Clocking: one clock; reset is asynchronous and active-high.
- `clk` in 1: clock; all state changes on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `m0_req`, `m1_req` in 1 each: request valid; held, with fields stable, until granted.
- `m0_we`, `m1_we` in 1 each: 1 = write, 0 = read.
- `m0_addr`, `m1_addr` in `ADDR_W` each: byte address; bits [1:0] ignored.
- `m0_wdata`, `m1_wdata` in 32 each: write data, lane-aligned.
- `m0_wstrb`, `m1_wstrb` in 4 each: byte-lane write enables.
- `m0_gnt`, `m1_gnt` out 1 each: request accepted this cycle.
- `m0_rvalid`, `m1_rvalid` out 1 each: one-cycle completion pulse, for reads and writes.
- `m0_rdata`, `m1_rdata` out 32 each: read word, valid with `rvalid`; 0 otherwise.
- `mem_read` out 1: drives memory `memread`.
- `mem_write` out 1: drives memory `memwrite`.
- `mem_addr` out `ADDR_W`: word-aligned address, bits [1:0] = 0.
- `mem_wdata` out 32: drives memory `write_data`.
- `mem_rdata` in 32: memory `read_data` (combinational).

## Operation
- States:
  - IDLE: arbitrates.
  - ACCESS: one memory cycle.
  - RMW_WR: second cycle of a partial write; exists only with the macro.
- IDLE, arbitration:
  - Grant is combinational, to at most one requester with `req`=1.
  - If both request, the grant goes to the `prio` side. `prio` resets to 0.
  - On a grant to k, `prio` becomes 1-k.
  - On a grant, the winner's id, we, addr[31:2], wdata and wstrb are latched; next state is ACCESS.
- ACCESS, read: `mem_read`=1, `mem_addr`=latched address; `mem_rdata` is registered into the response buffer.
- ACCESS, write:
  - `wstrb`=4'hF: `mem_write`=1 with `mem_wdata`=wdata.
  - `wstrb`=4'h0: no memory strobe asserted; the request still completes.
  - Partial strobe: handled per Configuration.
- RMW_WR: `mem_write`=1 with the merged word. Merged byte i is wdata byte i if wstrb[i], otherwise the byte read in ACCESS.
- Completion: the owning requester's `rvalid` pulses for exactly one cycle, in the cycle the FSM is back in IDLE. Its `rdata` carries the read word for reads and 0 for writes.
- Memory outputs:
  - Decoded from registered state only, never from requester inputs.
  - `mem_read` and `mem_write` are never both 1.
  - All `mem_*` outputs are 0 in IDLE.

## Timing
- Accept in cycle N (`gnt`=1) -> memory access in N+1 -> `rvalid` in N+2.
- Partial write with RMW: read in N+1, write in N+2, `rvalid` in N+3.
- A new grant may occur in the same cycle as an `rvalid`. Peak throughput is one transaction per 2 cycles.
- `gnt` is 0 outside IDLE; requests are held off.
- Requests arriving simultaneously are resolved by `prio` only. A lone requester always wins.
- Reset values: state=IDLE, `prio`=0, every output 0, latched request cleared.
- Reset asserted mid-transaction drops the transaction immediately:
  - no `rvalid`;
  - `mem_write` deasserts asynchronously, so a pending RMW write never occurs.

## Configuration
- Macro: `DMEM_ARB_RMW_EN`.
- Defined:
  - Partial `wstrb` (not 0, not F) takes the path ACCESS (read) -> RMW_WR (merged write).
  - The RMW_WR state, merge logic and old-word register are present.
- Undefined:
  - RMW_WR, the merge logic and the old-word register are absent.
  - Any nonzero `wstrb` performs a full-word write of wdata in ACCESS; 2-cycle latency.
  - `wstrb`=0 still suppresses the write.

## Structure
- Package `dmem_arb_pkg` holds:
  - the state enum `dmem_arb_state_t` (IDLE, ACCESS, RMW_WR);
  - constant `NUM_REQ`=2;
  - a packed struct `dmem_req_t` {we, addr, wdata, wstrb} for the latched request.
- Sub-module `rr_arb2`: two-input round-robin arbiter owning `prio`, with outputs grant[1:0] and a winner id. It is instantiated once.
- The byte merge stays inline, guarded by the macro.

## Test plan
- Reset, then m0 reads 0x10 (mem word 4 = 0xDEADBEEF): `m0_gnt` in cycle 1, `mem_read`=1 with `mem_addr`=0x10 in cycle 2, `m0_rvalid`=1 with `m0_rdata`=0xDEADBEEF in cycle 3.
- m0 and m1 both request continuously: grants alternate m0, m1, m0, m1; `m1_rvalid` never coincides with an m1 grant gap longer than 2 cycles.
- With the macro defined, m1 writes 0x000000AB with wstrb=4'b0001 to a word holding 0x11223344: `mem_read` then `mem_write` with 0x112233AB; `m1_rvalid` at N+3.
- Without the macro, the same stimulus produces a single `mem_write` of 0x000000AB in N+1 and `rvalid` at N+2.
- m0 write with wstrb=0: no `mem_write` is asserted, and `m0_rvalid` still pulses at N+2.
- Assert `rst` during RMW_WR: `mem_write` drops immediately, no `rvalid` is produced, the memory word is unchanged, and the first grant after reset goes to m0.
